rv32i_ifetch: RTL

//  Instruction fetch + register-field decode stage directly upstream of the register bank.

---
 rtl/rv32i_ifetch.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/rv32i_ifetch.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_ifetch
//  Brief    : RV32I instruction fetch and register-field decode in front of the
//             register bank. The RV32I_IFETCH_MISALIGN_EN macro adds a trap state
//             and a misalign_o port for misaligned redirects.
//  Revision : 1.0  initial release
// ============================================================================
module rv32i_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [3:0]  rs1_idx_o,
    output logic        rs1_hi_o,
    output logic [3:0]  rs2_idx_o,
    output logic        rs2_hi_o,
    output logic [3:0]  rd_idx_o,
    output logic        rd_hi_o,
    output logic        rd_we_o
`ifdef RV32I_IFETCH_MISALIGN_EN
   ,output logic        misalign_o
`endif
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_FLUSH = 3'd3
`ifdef RV32I_IFETCH_MISALIGN_EN
       ,ST_TRAP  = 3'd4
`endif
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic [31:0] instr_q;
    logic [31:0] pc_out_q;
    logic        req_q;
    logic        valid_q;
    logic        rd_we_q;

    logic [31:0] redir_pc_d;
    logic [31:0] pc_inc_d;
    logic        rd_we_d;

    always_comb begin
        redir_pc_d = redirect_pc_i & ~32'h3;
        pc_inc_d   = pc_q + 32'd4;
        case (imem_rdata_i[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_OP_IMM, OPC_OP: rd_we_d = (imem_rdata_i[11:7] != 5'd0);
            default:                      rd_we_d = 1'b0;
        endcase
    end

`ifdef RV32I_IFETCH_MISALIGN_EN
    logic misalign_q;
    logic redir_mis_d;
    assign redir_mis_d = (redirect_pc_i[1:0] != 2'b00);
`endif

    // addr_q is separate from pc_q so the bus address stays put while a
    // redirect moves pc_q during FLUSH.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            instr_q  <= 32'd0;
            pc_out_q <= 32'd0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            rd_we_q  <= 1'b0;
`ifdef RV32I_IFETCH_MISALIGN_EN
            misalign_q <= 1'b0;
`endif
        end else if (redirect_i) begin
`ifdef RV32I_IFETCH_MISALIGN_EN
            if (redir_mis_d) begin
                state_q    <= ST_TRAP;
                req_q      <= 1'b0;
                valid_q    <= 1'b0;
                misalign_q <= 1'b1;
                pc_q       <= redir_pc_d;
                pc_out_q   <= redirect_pc_i;
            end else begin
                misalign_q <= 1'b0;
`endif
                pc_q    <= redir_pc_d;
                valid_q <= 1'b0;
                // An unacknowledged request must still complete on the bus.
                if ((state_q == ST_WAIT || state_q == ST_FLUSH) && !imem_ack_i) begin
                    state_q <= ST_FLUSH;
                end else begin
                    state_q <= ST_WAIT;
                    req_q   <= 1'b1;
                    addr_q  <= redir_pc_d;
                end
`ifdef RV32I_IFETCH_MISALIGN_EN
            end
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_WAIT;
                    req_q   <= 1'b1;
                    addr_q  <= pc_q;
                end
                ST_WAIT: begin
                    if (imem_ack_i) begin
                        state_q  <= ST_HOLD;
                        req_q    <= 1'b0;
                        valid_q  <= 1'b1;
                        instr_q  <= imem_rdata_i;
                        pc_out_q <= pc_q;
                        rd_we_q  <= rd_we_d;
                    end
                end
                ST_HOLD: begin
                    if (instr_ready_i) begin
                        state_q <= ST_WAIT;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        pc_q    <= pc_inc_d;
                        addr_q  <= pc_inc_d;
                    end
                end
                ST_FLUSH: begin
                    if (imem_ack_i) begin
                        state_q <= ST_WAIT;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                    end
                end
`ifdef RV32I_IFETCH_MISALIGN_EN
                ST_TRAP: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_out_q;
    assign rs1_idx_o     = instr_q[18:15];
    assign rs1_hi_o      = instr_q[19];
    assign rs2_idx_o     = instr_q[23:20];
    assign rs2_hi_o      = instr_q[24];
    assign rd_idx_o      = instr_q[10:7];
    assign rd_hi_o       = instr_q[11];
    assign rd_we_o       = rd_we_q;
`ifdef RV32I_IFETCH_MISALIGN_EN
    assign misalign_o    = misalign_q;
`endif

endmodule
`default_nettype wire
